// File: rtl/booth_pkg.sv
// Shared definitions for the radix-16 Booth encode unit.
//   - FSM state enum
//   - operand / multiple width constants
//   - digit encoder: 5-bit overlapping group -> {neg, sel[3:0], shift[3:0]}
package booth_pkg;

    localparam int W1X  = 8;
    localparam int W3X  = 10;
    localparam int W5X  = 11;
    localparam int W7X  = 11;
    localparam int WADD = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC3 = 3'd1,
        ST_CALC5 = 3'd2,
        ST_CALC7 = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    typedef struct packed {
        logic       neg;
        logic [3:0] sel;    // one-hot: 1X, 3X, 5X, 7X
        logic [3:0] shift;  // one-hot: <<0 .. <<3
    } digit_enc_t;

    // Digit value d = -8*g4 + 4*g3 + 2*g2 + g1 + g0. The first four terms are
    // simply g[4:1] read as a signed nibble, so d = sext(g[4:1]) + g0, which
    // spans -8..+8 and fits a 5-bit signed result.
    function automatic digit_enc_t booth_digit(input logic [4:0] grp);
        logic [4:0] d;
        logic [4:0] mag;
        digit_enc_t r;
        d       = {grp[4], grp[4:1]} + {4'b0000, grp[0]};
        mag     = d[4] ? (~d + 5'd1) : d;
        r.neg   = d[4];
        r.sel   = 4'b0000;
        r.shift = 4'b0001;
        case (mag)
            5'd1: begin r.sel = 4'b0001; r.shift = 4'b0001; end
            5'd2: begin r.sel = 4'b0001; r.shift = 4'b0010; end
            5'd3: begin r.sel = 4'b0010; r.shift = 4'b0001; end
            5'd4: begin r.sel = 4'b0001; r.shift = 4'b0100; end
            5'd5: begin r.sel = 4'b0100; r.shift = 4'b0001; end
            5'd6: begin r.sel = 4'b0010; r.shift = 4'b0010; end
            5'd7: begin r.sel = 4'b1000; r.shift = 4'b0001; end
            5'd8: begin r.sel = 4'b0001; r.shift = 4'b1000; end
            default: begin r.sel = 4'b0000; r.shift = 4'b0001; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational Booth digit encoder for one radix-16 digit.
//   iGroup  : 5-bit overlapping multiplier group
//   oNeg    : digit is negative
//   oSel    : one-hot multiple select (1X, 3X, 5X, 7X); all-zero for a zero digit
//   oShift  : one-hot left-shift select (bit n = shift by n)
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [4:0] iGroup,
    output logic       oNeg,
    output logic [3:0] oSel,
    output logic [3:0] oShift
);

    digit_enc_t enc;

    assign enc    = booth_digit(iGroup);
    assign oNeg   = enc.neg;
    assign oSel   = enc.sel;
    assign oShift = enc.shift;

endmodule

// File: rtl/booth_encode_unit.sv
// Booth encode unit for an 8x8 signed radix-16 multiplier.
// Captures an operand pair, encodes both multiplier digits at capture, then
// builds 3A, 5A and 7A over three cycles on a single shared adder and holds
// the complete set until the downstream unit takes it.
//   iClk, iRst          : clock, synchronous active-high reset
//   iValid/oReady       : operand pair handshake (iDatA, iDatB)
//   oValid/iReady       : encoded set handshake
//   oDat1X..oDat7X      : A, 3A, 5A, 7A (signed)
//   oNegative           : per-digit sign, [0] low digit, [1] high digit
//   oBoothSel/oShiftSel : per-digit one-hot multiple / shift selects
//
// state  | meaning
// IDLE   | waiting for an operand pair, oReady high
// CALC3  | adder forms 3A
// CALC5  | adder forms 5A
// CALC7  | adder forms 7A
// HOLD   | set presented, oValid high until iReady
module booth_encode_unit
    import booth_pkg::*;
(
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [W1X-1:0]        iDatA,
    input  logic [7:0]            iDatB,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [W1X-1:0]        oDat1X,
    output logic [W3X-1:0]        oDat3X,
    output logic [W5X-1:0]        oDat5X,
    output logic [W7X-1:0]        oDat7X,
    output logic [1:0]            oNegative,
    output logic [1:0][3:0]       oBoothSel,
    output logic [1:0][3:0]       oShiftSel
);

    state_e              state_q, state_d;
    logic [W1X-1:0]      a_q;
    logic [W3X-1:0]      dat3x_q;
    logic [W5X-1:0]      dat5x_q;
    logic [W7X-1:0]      dat7x_q;
    logic [1:0]          neg_q;
    logic [1:0][3:0]     sel_q;
    logic [1:0][3:0]     shift_q;

    logic                accept;
    logic [1:0]          neg_w;
    logic [1:0][3:0]     sel_w;
    logic [1:0][3:0]     shift_w;

    logic [WADD-1:0]     ax;
    logic [WADD-1:0]     add_a;
    logic                add_sub;
    logic [WADD-1:0]     add_sum;

    // Low digit sees an implied zero below B[0]; high digit overlaps at B[3].
    booth_digit_enc u_enc_lo (
        .iGroup (iDatB[3:0] & 4'hF ? {iDatB[3:0], 1'b0} : 5'b00000),
        .oNeg   (neg_w[0]),
        .oSel   (sel_w[0]),
        .oShift (shift_w[0])
    );

    booth_digit_enc u_enc_hi (
        .iGroup (iDatB[7:3]),
        .oNeg   (neg_w[1]),
        .oSel   (sel_w[1]),
        .oShift (shift_w[1])
    );

    assign oReady = (state_q == ST_IDLE);
    assign oValid = (state_q == ST_HOLD);
    assign accept = iValid & oReady;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_CALC3;
            ST_CALC3: state_d = ST_CALC5;
            ST_CALC5: state_d = ST_CALC7;
            ST_CALC7: state_d = ST_HOLD;
            ST_HOLD:  if (iReady) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shared adder: (A << k) +/- A with A sign-extended to the full width.
    // Subtraction reuses the adder as a + ~b + 1.
    assign ax = {{(WADD-W1X){a_q[W1X-1]}}, a_q};

    always_comb begin
        add_a   = ax << 1;
        add_sub = 1'b0;
        case (state_q)
            ST_CALC5: add_a = ax << 2;
            ST_CALC7: begin
                add_a   = ax << 3;
                add_sub = 1'b1;
            end
            default: add_a = ax << 1;
        endcase
    end

    assign add_sum = add_a + (ax ^ {WADD{add_sub}}) + {{(WADD-1){1'b0}}, add_sub};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            dat3x_q <= '0;
            dat5x_q <= '0;
            dat7x_q <= '0;
            neg_q   <= '0;
            sel_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= iDatA;
                neg_q   <= neg_w;
                sel_q   <= sel_w;
                shift_q <= shift_w;
            end
            case (state_q)
                ST_CALC3: dat3x_q <= add_sum[W3X-1:0];
                ST_CALC5: dat5x_q <= add_sum;
                ST_CALC7: dat7x_q <= add_sum;
                default: ;
            endcase
        end
    end

    assign oDat1X    = a_q;
    assign oDat3X    = dat3x_q;
    assign oDat5X    = dat5x_q;
    assign oDat7X    = dat7x_q;
    assign oNegative = neg_q;
    assign oBoothSel = sel_q;
    assign oShiftSel = shift_q;

endmodule

// File: tb/tb_booth_encode_unit.sv
module tb_booth_encode_unit;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iValid;
    logic             oReady;
    logic [7:0]       iDatA;
    logic [7:0]       iDatB;
    logic             oValid;
    logic             iReady;
    logic [7:0]       oDat1X;
    logic [9:0]       oDat3X;
    logic [10:0]      oDat5X;
    logic [10:0]      oDat7X;
    logic [1:0]       oNegative;
    logic [1:0][3:0]  oBoothSel;
    logic [1:0][3:0]  oShiftSel;

    booth_encode_unit dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iDatA     (iDatA),
        .iDatB     (iDatB),
        .oValid    (oValid),
        .iReady    (iReady),
        .oDat1X    (oDat1X),
        .oDat3X    (oDat3X),
        .oDat5X    (oDat5X),
        .oDat7X    (oDat7X),
        .oNegative (oNegative),
        .oBoothSel (oBoothSel),
        .oShiftSel (oShiftSel)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Magnitude -> (multiple factor, shift) straight from the encoding table.
    int fac_t [0:8] = '{0, 1, 1, 3, 1, 5, 3, 7, 1};
    int sh_t  [0:8] = '{0, 0, 1, 0, 2, 0, 1, 0, 3};

    typedef struct {
        int         a;
        int         b;
        int         e3;
        int         e5;
        int         e7;
        logic [3:0] sel_lo;
        logic [3:0] sh_lo;
        logic       neg_lo;
        logic [3:0] sel_hi;
        logic [3:0] sh_hi;
        logic       neg_hi;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // B = 16*d_hi + d_lo with d_lo the signed value of B[3:0].
    function automatic int dig_lo(input int b);
        return ((b & 15) ^ 8) - 8;
    endfunction

    function automatic int dig_hi(input int b);
        return (b - dig_lo(b)) / 16;
    endfunction

    function automatic int abs_i(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int exp_sel(input int d);
        int f;
        f = fac_t[abs_i(d)];
        return (f == 0) ? 0 : (1 << ((f - 1) / 2));
    endfunction

    function automatic int exp_shift(input int d);
        return 1 << sh_t[abs_i(d)];
    endfunction

    function automatic int model_digit(input int d);
        int v;
        v = fac_t[abs_i(d)] * (1 << sh_t[abs_i(d)]);
        return (d < 0) ? -v : v;
    endfunction

    // Value contributed by one digit, interpreted from DUT outputs alone.
    function automatic int dut_digit(input logic [3:0] sel, input logic [3:0] sh, input logic neg,
                                     input int m1, input int m3, input int m5, input int m7);
        int m;
        int s;
        case (sel)
            4'b0000: m = 0;
            4'b0001: m = m1;
            4'b0010: m = m3;
            4'b0100: m = m5;
            4'b1000: m = m7;
            default: m = 99999;
        endcase
        case (sh)
            4'b0001: s = 0;
            4'b0010: s = 1;
            4'b0100: s = 2;
            4'b1000: s = 3;
            default: begin s = 0; m = 99999; end
        endcase
        m = m * (1 << s);
        return neg ? -m : m;
    endfunction

    function automatic logic [57:0] out_vec();
        return {oDat1X, oDat3X, oDat5X, oDat7X, oNegative, oBoothSel, oShiftSel};
    endfunction

    task automatic send(input int a, input int b);
        int n;
        n = 0;
        while (!oReady && n < 20) begin
            @(posedge iClk); #1;
            n++;
        end
        chk("ready_wait", oReady, 1);
        iDatA  = 8'(a);
        iDatB  = 8'(b);
        iValid = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
    endtask

    // Edges from the accept edge until oValid is seen: HOLD is entered on
    // the third edge after acceptance (the fourth cycle counting the accept cycle).
    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (!oValid && lat < 20) begin
            @(posedge iClk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
    endtask

    task automatic release_set(input string tag);
        iReady = 1'b1;
        @(posedge iClk); #1;
        iReady = 1'b0;
        chk({tag, "_valid_drop"}, oValid, 0);
        chk({tag, "_ready_back"}, oReady, 1);
    endtask

    task automatic check_set(input string tag, input int a, input int b);
        int dl, dh, m1, m3, m5, m7, pl, ph;
        dl = dig_lo(b);
        dh = dig_hi(b);
        m1 = int'($signed(oDat1X));
        m3 = int'($signed(oDat3X));
        m5 = int'($signed(oDat5X));
        m7 = int'($signed(oDat7X));
        chk({tag, "_1x"}, m1, a);
        chk({tag, "_3x"}, m3, 3 * a);
        chk({tag, "_5x"}, m5, 5 * a);
        chk({tag, "_7x"}, m7, 7 * a);
        chk({tag, "_sel_lo"}, oBoothSel[0], exp_sel(dl));
        chk({tag, "_sh_lo"},  oShiftSel[0], exp_shift(dl));
        chk({tag, "_neg_lo"}, oNegative[0], (dl < 0) ? 1 : 0);
        chk({tag, "_sel_hi"}, oBoothSel[1], exp_sel(dh));
        chk({tag, "_sh_hi"},  oShiftSel[1], exp_shift(dh));
        chk({tag, "_neg_hi"}, oNegative[1], (dh < 0) ? 1 : 0);
        pl = dut_digit(oBoothSel[0], oShiftSel[0], oNegative[0], m1, m3, m5, m7);
        ph = dut_digit(oBoothSel[1], oShiftSel[1], oNegative[1], m1, m3, m5, m7);
        chk({tag, "_product"}, pl + 16 * ph, a * b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [57:0] snap;
        int          bad;
        int          hi_cnt;

        vecs[0] = '{5,    3,    15,   25,   35,   4'b0010, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b0};
        vecs[1] = '{-128, -128, -384, -640, -896, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b1000, 1'b1};
        vecs[2] = '{1,    127,  3,    5,    7,    4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b1000, 1'b0};
        vecs[3] = '{127,  -1,   381,  635,  889,  4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0};
        vecs[4] = '{-7,   90,   -21,  -35,  -49,  4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0};

        iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iDatA = '0; iDatB = '0;
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_valid", oValid, 0);
        chk("rst_ready", oReady, 1);
        chk("rst_data",  out_vec(), 0);
        iRst = 1'b0;

        // Reference recoding over every operand pair.
        bad = 0;
        for (int a = -128; a < 128; a++) begin
            for (int b = -128; b < 128; b++) begin
                if (abs_i(dig_lo(b)) > 8 || abs_i(dig_hi(b)) > 8 ||
                    a * (model_digit(dig_lo(b)) + 16 * model_digit(dig_hi(b))) != a * b)
                    bad++;
            end
        end
        chk("sweep_model_mismatches", bad, 0);

        for (int i = 0; i < 5; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            send(vecs[i].a, vecs[i].b);
            wait_valid(t);
            chk({t, "_3x"},     int'($signed(oDat3X)), vecs[i].e3);
            chk({t, "_5x"},     int'($signed(oDat5X)), vecs[i].e5);
            chk({t, "_7x"},     int'($signed(oDat7X)), vecs[i].e7);
            chk({t, "_sel_lo"}, oBoothSel[0], vecs[i].sel_lo);
            chk({t, "_sh_lo"},  oShiftSel[0], vecs[i].sh_lo);
            chk({t, "_neg_lo"}, oNegative[0], vecs[i].neg_lo);
            chk({t, "_sel_hi"}, oBoothSel[1], vecs[i].sel_hi);
            chk({t, "_sh_hi"},  oShiftSel[1], vecs[i].sh_hi);
            chk({t, "_neg_hi"}, oNegative[1], vecs[i].neg_hi);
            check_set({t, "_m"}, vecs[i].a, vecs[i].b);
            release_set(t);
        end

        // Backpressure: set held for 10 cycles, new operands offered meanwhile.
        send(9, -77);
        wait_valid("bp");
        snap = out_vec();
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                iValid = 1'b1; iDatA = 8'h55; iDatB = 8'h22;
            end
            @(posedge iClk); #1;
            iValid = 1'b0;
            chk("bp_valid",  oValid, 1);
            chk("bp_ready",  oReady, 0);
            chk("bp_stable", out_vec(), snap);
        end
        check_set("bp", 9, -77);
        release_set("bp");

        // Reset during CALC5 discards the operation.
        send(-100, 45);
        @(posedge iClk); #1;
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        chk("midrst_valid", oValid, 0);
        chk("midrst_ready", oReady, 1);
        chk("midrst_data",  out_vec(), 0);
        hi_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge iClk); #1;
            if (oValid) hi_cnt++;
        end
        chk("midrst_no_partial", hi_cnt, 0);
        send(-100, 45);
        wait_valid("post_rst");
        check_set("post_rst", -100, 45);
        release_set("post_rst");

        for (int n = 0; n < 150; n++) begin
            logic [7:0] ra, rb;
            int a, b, hold;
            ra = 8'($urandom);
            rb = 8'($urandom);
            a = int'($signed(ra));
            b = int'($signed(rb));
            send(a, b);
            wait_valid("rnd");
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(posedge iClk); #1;
            end
            check_set("rnd", a, b);
            release_set("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
